approx_mul8_rr_arbiter: RTL and testbench
=========================================

# approx_mul8_rr_arbiter

Shares one approximate unsigned 8x8 multiplier datapath among NREQ requesters. Requests are granted round-robin, pipelined through a two-stage operand/product register pipe, and returned on a single tagged response channel with full backpressure. A global mode input selects approximate or exact products, and a statistics counter tracks approximate operations. It sits between accelerator lanes issuing 8-bit multiplies and the shared multiplier resource.

## Interface
- NREQ, 4, number of requesters, 2..8
- IDW, $clog2(NREQ), response tag width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept
- req_x  in  NREQ*8  multiplicand; requester i occupies bits [8i+7:8i]
- req_y  in  NREQ*8  multiplier, same packing
- cfg_approx  in  1  1 = approximate product, 0 = exact; sampled at accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_z  out  16  product
- rsp_id  out  IDW  index of the originating requester
- rsp_approx  out  1  mode the product was computed in
- stat_approx_cnt  out  16  count of delivered approximate responses, wraps

## Operation
- Approximate product, bit-exact: P = 4*y*floor(x/4) + 128*((x0&y6)|(x1&y5)) + 256*(x1&y7) + 128*((x0&y7)|(x1&y6)), truncated to 16 bits. Exact product: P = x*y.
- Arbitration: rotating pointer `ptr`, reset 0. Grant goes to the first asserted req_valid at index ptr, ptr+1, … (mod NREQ).
- On accept of index g, ptr becomes (g+1) mod NREQ. Without an accept, ptr holds.
- req_ready[i] = grant[i] & s1_free. At most one bit is set.
- req_ready may depend combinationally on req_valid. Requester valid must not depend on ready. Once asserted, valid and operands stay stable until accepted.
- Stage 1 (s1) registers x, y, id and approx at accept.
- Stage 2 (s2) registers P computed from s1, plus id and approx. s2 drives rsp_*.
- s2_free = !rsp_valid | rsp_ready.
- s1_free = !s1_valid | s2_free.
- s1 advances into s2 when s1_valid & s2_free.
- stat_approx_cnt increments by 1 on each rsp_valid & rsp_ready with rsp_approx = 1.
- Reset (any time, including mid-transfer) clears both pipeline stages. In-flight operations are dropped, not replayed.
- Reset values: rsp_valid 0, rsp_z 0, rsp_id 0, rsp_approx 0, req_ready 0, ptr 0, stat_approx_cnt 0.

## Timing
- Latency: an accept at edge k produces rsp_valid high from just after edge k+1 when s2 is free. The result is therefore presentable at edge k+2.
- Throughput: one accept per cycle while rsp_ready stays high; back-to-back accepts from different or the same requester are legal.
- Backpressure:
  - With rsp_ready low and s2 full, s1 holds.
  - s1 accepts one more request only if empty. After that, req_ready is 0 for all requesters.
  - rsp_* are stable while rsp_valid & !rsp_ready.
- Simultaneous events: response drain and new accept in the same cycle are both honoured, with no bubble.
- A requester deasserting valid never happens before accept, by protocol. Behaviour is undefined if it does.
- cfg_approx changes affect only requests accepted after the change.
- stat_approx_cnt wraps 0xFFFF → 0x0000.

## Structure
- Package approx_mul_pkg:
  - OPW = 8 and PW = 16.
  - Function approx_mul8(x, y) returning the 16-bit approximate product. Shared by RTL core and testbench model.
- Sub-module approx_mul8_core: purely combinational, inputs x, y, approx; output z. Instantiated once between s1 and s2.
- Arbiter, pipeline registers and counter live in the top.

## Test plan
- Single request: requester 2, x=0xA5, y=0x3C, approx=1, rsp_ready=1 → rsp_z=9840, rsp_id=2, result two edges after accept; with approx=0 → 9900.
- Compensation bits: x=3, y=255 → approx 512, exact 765; x=255, y=255 → approx 64772, exact 65025.
- Fairness: all four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1…; one accept per cycle, rsp_id sequence matches.
- Backpressure: hold rsp_ready=0 for 5 cycles under full load → exactly two operations buffered (s2, s1), req_ready all 0, rsp_* stable. Release → drain in order, no loss or duplication.
- Reset mid-stream: assert rst with s1 and s2 full → rsp_valid 0 immediately (async), ptr 0, stat_approx_cnt 0. After release, the next grant goes to the lowest valid index.
- Counter: deliver 0x10000 approximate plus 3 exact responses → stat_approx_cnt reads 0x0000 (wrap); exact responses do not count.

Source files
------------

// File: rtl/approx_mul8_rr_arbiter_pkg.sv
// Shared widths and the approximate 8x8 product used by the multiplier core.
package approx_mul_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;

  // Truncated partial-product multiply: the two low multiplicand bits are
  // dropped from the array and replaced by three compensation terms that
  // only look at the top multiplier bits.
  function automatic logic [PW-1:0] approx_mul8(input logic [OPW-1:0] x,
                                                 input logic [OPW-1:0] y);
    logic [PW-1:0] base;
    logic [PW-1:0] comp;
    base = PW'(y) * PW'(x[OPW-1:2]);
    comp = (PW'((x[0] & y[6]) | (x[1] & y[5])) << 7)
         + (PW'(x[1] & y[7]) << 8)
         + (PW'((x[0] & y[7]) | (x[1] & y[6])) << 7);
    return (base << 2) + comp;
  endfunction

endpackage

// File: rtl/approx_mul8_rr_arbiter_if.sv
// Request/response bundle between the accelerator lanes and the shared multiplier.
interface approx_mul8_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  import approx_mul_pkg::*;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_x;
  logic [NREQ*OPW-1:0] req_y;
  logic                cfg_approx;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [PW-1:0]       rsp_z;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_approx;
  logic [15:0]         stat_approx_cnt;

  modport master (
    output req_valid, req_x, req_y, cfg_approx, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id, rsp_approx, stat_approx_cnt
  );

  modport slave (
    input  req_valid, req_x, req_y, cfg_approx, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id, rsp_approx, stat_approx_cnt
  );

endinterface

// File: rtl/approx_mul8_rr_arbiter_core.sv
// Combinational multiplier: exact product or the truncated approximation.
module approx_mul8_core
  import approx_mul_pkg::*;
(
  input  logic [OPW-1:0] x,
  input  logic [OPW-1:0] y,
  input  logic           approx,
  output logic [PW-1:0]  z
);

  // Pick between the approximate array and a full multiply.
  always_comb begin
    if (approx) z = approx_mul8(x, y);
    else        z = PW'(x) * PW'(y);
  end

endmodule

// File: rtl/approx_mul8_rr_arbiter.sv
// Round-robin front end, two-stage operand/product pipe and approx-op counter
// around one shared approximate multiplier.
module approx_mul8_rr_arbiter
  import approx_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic                     clk,
  input logic                     rst,
  approx_mul8_rr_arbiter_if.slave bus
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  int              scan_idx;
  logic [NREQ-1:0] ready_vec;

  logic            s1_valid;
  logic [OPW-1:0]  s1_x;
  logic [OPW-1:0]  s1_y;
  logic [IDW-1:0]  s1_id;
  logic            s1_approx;

  logic            s2_valid;
  logic [PW-1:0]   s2_z;
  logic [IDW-1:0]  s2_id;
  logic            s2_approx;

  logic [15:0]     stat_cnt;
  logic            s2_free;
  logic            s1_free;
  logic            accept;
  logic [PW-1:0]   core_z;

  // s2 can take new data when it is empty or being drained this cycle;
  // s1 can take a request when it is empty or moving into s2.
  assign s2_free = !s2_valid || bus.rsp_ready;
  assign s1_free = !s1_valid || s2_free;
  assign accept  = grant_any && s1_free;

  // Scan requesters starting at the rotating pointer and take the first one valid.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!grant_any && bus.req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(scan_idx);
      end
    end
  end

  // One-hot ready to the granted requester, held low while in reset.
  always_comb begin
    ready_vec = '0;
    if (grant_any && s1_free && !rst) ready_vec[grant_idx] = 1'b1;
  end

  // Advance the pointer past whoever was just accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      if (int'(grant_idx) == NREQ - 1) ptr <= '0;
      else                             ptr <= grant_idx + 1'b1;
    end
  end

  // Stage 1 captures operands, origin and mode at the moment of accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_id     <= '0;
      s1_approx <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_x      <= bus.req_x[int'(grant_idx)*OPW +: OPW];
      s1_y      <= bus.req_y[int'(grant_idx)*OPW +: OPW];
      s1_id     <= grant_idx;
      s1_approx <= bus.cfg_approx;
    end else if (s2_free) begin
      s1_valid  <= 1'b0;
    end
  end

  approx_mul8_core u_core (
    .x      (s1_x),
    .y      (s1_y),
    .approx (s1_approx),
    .z      (core_z)
  );

  // Stage 2 holds the product and is the response register; it only moves when free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_z      <= '0;
      s2_id     <= '0;
      s2_approx <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_z      <= core_z;
        s2_id     <= s1_id;
        s2_approx <= s1_approx;
      end
    end
  end

  // Count delivered approximate responses, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt <= '0;
    end else if (s2_valid && bus.rsp_ready && s2_approx) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end

  assign bus.req_ready       = ready_vec;
  assign bus.rsp_valid       = s2_valid;
  assign bus.rsp_z           = s2_z;
  assign bus.rsp_id          = s2_id;
  assign bus.rsp_approx      = s2_approx;
  assign bus.stat_approx_cnt = stat_cnt;

endmodule

// File: tb/tb_approx_mul8_rr_arbiter.sv
// Randomized bench for the shared approximate multiplier with an in-order
// queue model of the pipe and a handful of hand-computed expectations.
module tb_approx_mul8_rr_arbiter;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  approx_mul8_rr_arbiter_if #(.NREQ(NREQ)) bus ();

  approx_mul8_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: operations in delivery order; 'shown' marks the one on the response port.
  typedef struct {
    int x;
    int y;
    int id;
    bit a;
    bit shown;
  } item_t;

  item_t pipe_q[$];
  int    ptr_m     = 0;
  int    cnt_m     = 0;
  int    acc_idx   = -1;
  int    acc_total = 0;

  // Requester-side state and stimulus knobs.
  bit          rv[NREQ];
  logic [7:0]  rx[NREQ];
  logic [7:0]  ry[NREQ];
  logic [NREQ-1:0] en_mask = '0;
  int          load_pct = 0;
  int          rdy_pct  = 100;
  bit          cfg_rand = 1'b0;
  bit          cfg_val  = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Product straight from the arithmetic definition.
  function automatic int ref_prod(input int x, input int y, input bit a);
    int p;
    int x0, x1, y5, y6, y7;
    if (!a) return x * y;
    x0 = x & 1;         x1 = (x >> 1) & 1;
    y5 = (y >> 5) & 1;  y6 = (y >> 6) & 1;  y7 = (y >> 7) & 1;
    p = 4 * y * (x / 4) + 128 * ((x0 & y6) | (x1 & y5)) + 256 * (x1 & y7)
      + 128 * ((x0 & y7) | (x1 & y6));
    return p & 32'hFFFF;
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr_m + k) % NREQ;
      if (bus.req_valid[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  function automatic bit model_shown();
    return (pipe_q.size() > 0) && pipe_q[0].shown;
  endfunction

  function automatic bit model_s2_free();
    return !model_shown() || (bus.rsp_ready === 1'b1);
  endfunction

  function automatic bit model_s1_free();
    bit busy;
    busy = (pipe_q.size() == 2) || (pipe_q.size() == 1 && !pipe_q[0].shown);
    return !busy || model_s2_free();
  endfunction

  // Model update on each clock edge, cleared on reset.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pipe_q.delete();
      ptr_m   = 0;
      cnt_m   = 0;
      acc_idx = -1;
    end else begin
      int  g;
      bit  s1f;
      bit  s2f;
      item_t it;
      g   = model_grant();
      s1f = model_s1_free();
      s2f = model_s2_free();
      if (model_shown() && bus.rsp_ready === 1'b1) begin
        if (pipe_q[0].a) cnt_m = (cnt_m + 1) & 32'hFFFF;
        void'(pipe_q.pop_front());
      end
      if (s2f && pipe_q.size() > 0 && !pipe_q[0].shown) pipe_q[0].shown = 1'b1;
      if (g >= 0 && s1f) begin
        it.x = int'(bus.req_x[g*8 +: 8]);
        it.y = int'(bus.req_y[g*8 +: 8]);
        it.id = g;
        it.a = bus.cfg_approx;
        it.shown = 1'b0;
        pipe_q.push_back(it);
        ptr_m = (g + 1) % NREQ;
        acc_idx = g;
        acc_total++;
      end else begin
        acc_idx = -1;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  task automatic check_output();
    int g;
    logic [NREQ-1:0] exp_ready;
    g = model_grant();
    exp_ready = '0;
    if (!rst && g >= 0 && model_s1_free()) exp_ready[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(model_shown()));
    check("stat_cnt", 32'(bus.stat_approx_cnt), 32'(cnt_m));
    if (model_shown()) begin
      check("rsp_z", 32'(bus.rsp_z), 32'(ref_prod(pipe_q[0].x, pipe_q[0].y, pipe_q[0].a)));
      check("rsp_id", 32'(bus.rsp_id), 32'(pipe_q[0].id));
      check("rsp_approx", 32'(bus.rsp_approx), 32'(pipe_q[0].a));
    end
  endtask

  initial forever begin
    @(negedge clk);
    check_output();
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]      = rv[i];
      bus.req_x[i*8 +: 8]   = rx[i];
      bus.req_y[i*8 +: 8]   = ry[i];
    end
  endtask

  // Load idle enabled requesters, pick rsp_ready and mode, then drive the bus.
  task automatic apply_stimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (!rv[i] && en_mask[i] && $urandom_range(99) < load_pct) begin
        rv[i] = 1'b1;
        rx[i] = 8'($urandom);
        ry[i] = 8'($urandom);
      end
    end
    bus.rsp_ready  = ($urandom_range(99) < rdy_pct);
    bus.cfg_approx = cfg_rand ? 1'($urandom) : cfg_val;
    drive();
  endtask

  // Step to just after the next rising edge and retire whatever was accepted there.
  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_idx >= 0) rv[acc_idx] = 1'b0;
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    drive();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated request with a hand-computed product.
  task automatic single_op(input int id, input int x, input int y, input bit a, input int exp_z);
    en_mask  = '0;
    cfg_rand = 1'b0;
    cfg_val  = a;
    rdy_pct  = 100;
    rv[id] = 1'b1;
    rx[id] = 8'(x);
    ry[id] = 8'(y);
    bus.rsp_ready  = 1'b1;
    bus.cfg_approx = a;
    drive();
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'(1 << id));
    tick();
    apply_stimulus();
    @(negedge clk);
    check("single_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    apply_stimulus();
    @(negedge clk);
    check("single_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_z", 32'(bus.rsp_z), 32'(exp_z));
    check("single_id", 32'(bus.rsp_id), 32'(id));
    check("single_mode", 32'(bus.rsp_approx), 32'(a));
    tick();
    apply_stimulus();
  endtask

  initial begin
    int base;
    bit reached;
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0;
      rx[i] = '0;
      ry[i] = '0;
    end
    bus.rsp_ready  = 1'b1;
    bus.cfg_approx = 1'b0;
    drive();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_z", 32'(bus.rsp_z), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_rsp_approx", 32'(bus.rsp_approx), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_stat", 32'(bus.stat_approx_cnt), 32'd0);
    rst = 1'b0;

    $display("[TB] directed single operations");
    single_op(2, 8'hA5, 8'h3C, 1'b1, 9840);
    single_op(2, 8'hA5, 8'h3C, 1'b0, 9900);
    single_op(1, 3, 255, 1'b1, 512);
    single_op(0, 3, 255, 1'b0, 765);
    single_op(3, 255, 255, 1'b1, 64772);
    single_op(2, 255, 255, 1'b0, 65025);

    $display("[TB] fairness under full load");
    reset_dut();
    en_mask  = 4'hF;
    load_pct = 100;
    rdy_pct  = 100;
    cfg_rand = 1'b1;
    apply_stimulus();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("fair_grant", 32'(bus.req_ready), 32'(1 << (i % 4)));
      tick();
      apply_stimulus();
    end

    $display("[TB] backpressure");
    rdy_pct = 0;
    repeat (5) begin
      tick();
      apply_stimulus();
    end
    @(negedge clk);
    check("bp_ready_low", 32'(bus.req_ready), 32'd0);
    check("bp_rsp_held", 32'(bus.rsp_valid), 32'd1);
    rdy_pct = 100;
    repeat (10) begin
      tick();
      apply_stimulus();
    end

    $display("[TB] randomized traffic");
    load_pct = 40;
    rdy_pct  = 70;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) rdy_pct = $urandom_range(20, 100);
      if (c % 250 == 0) load_pct = $urandom_range(10, 100);
      tick();
      apply_stimulus();
    end

    $display("[TB] reset with a full pipe");
    load_pct = 100;
    rdy_pct  = 0;
    repeat (3) begin
      tick();
      apply_stimulus();
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_stat", 32'(bus.stat_approx_cnt), 32'd0);
    en_mask = '0;
    for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    rv[1] = 1'b1;
    rv[3] = 1'b1;
    bus.rsp_ready = 1'b1;
    rdy_pct = 100;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    apply_stimulus();
    @(negedge clk);
    check("post_rst_next", 32'(bus.req_ready), 32'b1000);
    repeat (4) begin
      tick();
      apply_stimulus();
    end

    $display("[TB] counter wrap");
    reset_dut();
    en_mask  = 4'b0001;
    load_pct = 100;
    rdy_pct  = 100;
    cfg_rand = 1'b0;
    cfg_val  = 1'b1;
    base     = acc_total;
    reached  = 1'b0;
    apply_stimulus();
    for (int c = 0; c < 70000; c++) begin
      tick();
      if (acc_total - base == 65536) cfg_val = 1'b0;
      if (acc_total - base == 65539) begin
        en_mask = '0;
        apply_stimulus();
        reached = 1'b1;
        break;
      end
      apply_stimulus();
    end
    check("wrap_accepts", 32'(reached), 32'd1);
    repeat (4) begin
      tick();
      apply_stimulus();
    end
    @(negedge clk);
    check("wrap_stat", 32'(bus.stat_approx_cnt), 32'd0);
    check("wrap_idle", 32'(bus.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
